// File: rtl/neuron_pkg.sv
// neuron_pkg
//   Shared definitions for the layer scheduler: default geometry, the
//   scheduler state encoding and the Q5.11 most-negative constant.
package neuron_pkg;

  localparam int N_DEF       = 16;  // Q5.11 signed word
  localparam int NUM_NEU_DEF = 4;   // neurons per layer
  localparam int NEU_W_DEF   = 2;   // clog2(NUM_NEU_DEF)
  localparam int TIMEOUT_DEF = 64;  // engine response limit in cycles

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  // Most-negative Q5.11 value; seeds the argmax so any real result wins.
  localparam logic signed [15:0] Q5_11_MOST_NEG = 16'sh8000;

endpackage

// File: rtl/neuron_layer_sched_watchdog.sv
// sched_watchdog
//   Engine-response watchdog. Counts enabled cycles while inc=1, returns to
//   zero on clr (clr has priority) and saturates at TIMEOUT-1.
//   Ports:
//     clk, rst     clock / synchronous active-high reset
//     ena          global enable, 0 = counter holds
//     clr          zero the counter
//     inc          count this cycle
//     expire       counter has reached TIMEOUT-1
module sched_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (ena) begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == LAST);

endmodule

// File: rtl/neuron_layer_sched.sv
// neuron_layer_sched
//   Runs one shared single-neuron engine over NUM_NEU neurons for each
//   accepted input word, collects the results in a layer buffer and reports
//   the index of the largest (signed) result.
//   Ports:
//     clk, rst, ena            clock, synchronous active-high reset, enable
//     in_valid/in_ready/in_data   input word handshake
//     eng_start/eng_sel/eng_data  engine launch: pulse, neuron index, word
//     eng_res/eng_rdy             engine result and its 1-cycle strobe
//     out_valid/out_ready         layer result handshake
//     out_data                    buf[k] at bits [k*N +: N]
//     out_max                     index of the largest result
//     busy                        scheduler not idle
//     err_timeout                 sticky: engine failed to answer in time
module neuron_layer_sched
  import neuron_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int NUM_NEU = NUM_NEU_DEF,
  parameter int NEU_W   = NEU_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  output logic                 eng_start,
  output logic [NEU_W-1:0]     eng_sel,
  output logic [N-1:0]         eng_data,
  input  logic [N-1:0]         eng_res,
  input  logic                 eng_rdy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*NUM_NEU-1:0] out_data,
  output logic [NEU_W-1:0]     out_max,
  output logic                 busy,
  output logic                 err_timeout
);

  // Equals Q5_11_MOST_NEG at the default width.
  localparam logic [N-1:0]     MOST_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [NEU_W-1:0] LAST_IDX = NEU_W'(NUM_NEU - 1);

  state_t           state_q, state_d;
  logic [NEU_W-1:0] idx_q, idx_d;
  logic [N-1:0]     data_q, data_d;
  logic [N-1:0]     max_q, max_d;
  logic [NEU_W-1:0] out_max_q, out_max_d;
  logic             err_q, err_d;
  logic [N-1:0]     buf_q [NUM_NEU];
  logic [N-1:0]     buf_d [NUM_NEU];

  logic wd_clr;
  logic wd_inc;
  logic wd_expire;

  // The timer is zero on entry to LAUNCH and keeps counting through LAUNCH
  // and WAIT, so a missing response raises err_timeout exactly TIMEOUT
  // cycles after the launch. It restarts on every accepted result.
  assign wd_clr = (state_q == ST_IDLE) || (state_q == ST_OUTPUT) ||
                  ((state_q == ST_WAIT) && eng_rdy);
  assign wd_inc = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);

  sched_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .expire (wd_expire)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      max_q     <= '0;
      out_max_q <= '0;
      err_q     <= 1'b0;
      for (int k = 0; k < NUM_NEU; k++) begin
        buf_q[k] <= '0;
      end
    end else if (ena) begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      max_q     <= max_d;
      out_max_q <= out_max_d;
      err_q     <= err_d;
      for (int k = 0; k < NUM_NEU; k++) begin
        buf_q[k] <= buf_d[k];
      end
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        // A result arriving in the expiry cycle still counts.
        if (eng_rdy) begin
          state_d = (idx_q == LAST_IDX) ? ST_OUTPUT : ST_LAUNCH;
        end else if (wd_expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_OUTPUT: if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_comb begin
    idx_d     = idx_q;
    data_d    = data_q;
    max_d     = max_q;
    out_max_d = out_max_q;
    err_d     = err_q;
    for (int k = 0; k < NUM_NEU; k++) begin
      buf_d[k] = buf_q[k];
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d    = in_data;
          idx_d     = '0;
          max_d     = MOST_NEG;
          out_max_d = '0;
        end
      end
      ST_WAIT: begin
        if (eng_rdy) begin
          buf_d[idx_q] = eng_res;
          // Strict compare: on a tie the earlier neuron keeps the argmax.
          if ($signed(eng_res) > $signed(max_q)) begin
            max_d     = eng_res;
            out_max_d = idx_q;
          end
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 1'b1;
          end
        end else if (wd_expire) begin
          // Partial results stay in the buffer; no result is presented.
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    in_ready    = (state_q == ST_IDLE);
    eng_start   = (state_q == ST_LAUNCH);
    out_valid   = (state_q == ST_OUTPUT);
    busy        = (state_q != ST_IDLE);
    eng_sel     = idx_q;
    eng_data    = data_q;
    out_max     = out_max_q;
    err_timeout = err_q;
  end

  for (genvar gi = 0; gi < NUM_NEU; gi++) begin : g_out_pack
    assign out_data[gi*N +: N] = buf_q[gi];
  end

endmodule

// File: tb/tb_neuron_layer_sched.sv
// tb_neuron_layer_sched
//   Directed bench for neuron_layer_sched with a behavioural engine of
//   latency 5 whose result depends only on the selected neuron.
module tb_neuron_layer_sched;
  import neuron_pkg::*;

  localparam int N       = 16;
  localparam int NUM_NEU = 4;
  localparam int NEU_W   = 2;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 ena = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [N-1:0]         in_data = '0;
  logic                 eng_start;
  logic [NEU_W-1:0]     eng_sel;
  logic [N-1:0]         eng_data;
  logic [N-1:0]         eng_res = '0;
  logic                 eng_rdy = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [N*NUM_NEU-1:0] out_data;
  logic [NEU_W-1:0]     out_max;
  logic                 busy;
  logic                 err_timeout;

  neuron_layer_sched #(
    .N(N), .NUM_NEU(NUM_NEU), .NEU_W(NEU_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .eng_start(eng_start), .eng_sel(eng_sel), .eng_data(eng_data),
    .eng_res(eng_res), .eng_rdy(eng_rdy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_max(out_max), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------ engine model
  int mute_sel = -1;  // neuron index the engine never answers
  int tbl_mode = 0;   // 0: main table, 1: small ramp, 2: all negative

  function automatic logic [N-1:0] res_for(input int mode, input logic [NEU_W-1:0] sel);
    logic [N-1:0] r;
    r = 16'h0000;
    if (mode == 2) begin
      r = 16'hF800;
    end else if (mode == 1) begin
      case (sel)
        2'd0: r = 16'h0100;
        2'd1: r = 16'h0200;
        2'd2: r = 16'h0300;
        default: r = 16'h0400;
      endcase
    end else begin
      case (sel)
        2'd0: r = 16'h0800;
        2'd1: r = 16'h1000;
        2'd2: r = 16'h0400;
        default: r = 16'h1000;
      endcase
    end
    return r;
  endfunction

  logic             eng_pend = 1'b0;
  int               eng_cnt  = 0;
  logic [NEU_W-1:0] eng_psel = '0;

  // The engine shares ena; it is not reset by the scheduler's rst.
  always @(posedge clk) begin
    if (ena) begin
      if (eng_rdy) eng_rdy <= 1'b0;
      if (eng_pend) begin
        if (eng_cnt == 1) begin
          eng_rdy  <= 1'b1;
          eng_res  <= res_for(tbl_mode, eng_psel);
          eng_pend <= 1'b0;
        end
        eng_cnt <= eng_cnt - 1;
      end
      if (eng_start && !eng_pend && (int'(eng_sel) != mute_sel)) begin
        eng_pend <= 1'b1;
        eng_cnt  <= LAT - 1;
        eng_psel <= eng_sel;
      end
    end
  end

  // Start monitor: counts enabled start cycles and logs the selected neuron.
  int               start_cnt = 0;
  logic [NEU_W-1:0] sel_log[$];

  always @(posedge clk) begin
    if (ena && eng_start) begin
      start_cnt <= start_cnt + 1;
      sel_log.push_back(eng_sel);
    end
  end

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Presents one word; returns in the LAUNCH cycle of neuron 0.
  task automatic accept(input logic [N-1:0] d, output int t0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    check("accept_in_ready", 64'(in_ready), 64'd1);
    t0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string tag, output int at);
    bit found;
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        at    = cyc;
      end
    end
    check(tag, 64'(found), 64'd1);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rel_out_valid", 64'(out_valid), 64'd0);
    check("rel_in_ready", 64'(in_ready), 64'd1);
  endtask

  // ------------------------------------------------------------------ stimulus
  localparam logic [63:0] EXP_MAIN = 64'h1000_0400_1000_0800;

  initial begin
    int t0;
    int at;
    int s0;
    int base;
    bit saw_ov;
    bit got_err;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_eng_start", 64'(eng_start), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    check("rst_out_max", 64'(out_max), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    rst = 1'b0;

    // 1: main table, latency, argmax tie, hold under backpressure.
    tbl_mode = 0;
    s0 = start_cnt;
    accept(16'hA5A5, t0);
    check("t1_start", 64'(eng_start), 64'd1);
    check("t1_sel0", 64'(eng_sel), 64'd0);
    check("t1_eng_data", 64'(eng_data), 64'hA5A5);
    check("t1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t1_start_pulse", 64'(eng_start), 64'd0);
    wait_out_valid("t1_ov_wait", at);
    check("t1_latency", 64'(at - t0), 64'd25);
    check("t1_out_data", out_data, EXP_MAIN);
    check("t1_out_max", 64'(out_max), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h1234;
      check("t1_hold_valid", 64'(out_valid), 64'd1);
      check("t1_hold_in_ready", 64'(in_ready), 64'd0);
      check("t1_hold_data", out_data, EXP_MAIN);
      check("t1_hold_max", 64'(out_max), 64'd1);
    end
    in_valid = 1'b0;
    release_out();
    check("t1_starts", 64'(start_cnt - s0), 64'd4);
    $display("txn 1: out_data=%h out_max=%0d latency=%0d", out_data, out_max, at - t0);

    // 2: engine silent on neuron 2 -> timeout.
    tbl_mode = 1;
    mute_sel = 2;
    accept(16'h0F0F, t0);
    saw_ov  = 1'b0;
    got_err = 1'b0;
    at      = -1;
    for (int i = 0; i < 200 && !got_err; i++) begin
      @(negedge clk);
      if (out_valid) saw_ov = 1'b1;
      if (err_timeout) begin
        got_err = 1'b1;
        at      = cyc;
      end
    end
    check("t2_err_seen", 64'(got_err), 64'd1);
    check("t2_err_time", 64'(at - (t0 + 13)), 64'(TIMEOUT));
    check("t2_busy", 64'(busy), 64'd0);
    check("t2_in_ready", 64'(in_ready), 64'd1);
    check("t2_no_ov", 64'(saw_ov), 64'd0);
    check("t2_partial", out_data, 64'h1000_0400_0200_0100);
    check("t2_out_max", 64'(out_max), 64'd1);
    mute_sel = -1;
    repeat (3) @(negedge clk);
    $display("txn 2: timeout at +%0d after launch 2, out_data=%h", at - (t0 + 13), out_data);

    // 3: ena low for 3 cycles in WAIT of neuron 0.
    tbl_mode = 0;
    s0 = start_cnt;
    accept(16'h5A5A, t0);
    @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    wait_out_valid("t3_ov_wait", at);
    check("t3_latency", 64'(at - t0), 64'd28);
    check("t3_out_data", out_data, EXP_MAIN);
    check("t3_out_max", 64'(out_max), 64'd1);
    check("t3_err_sticky", 64'(err_timeout), 64'd1);
    release_out();
    check("t3_starts", 64'(start_cnt - s0), 64'(NUM_NEU));
    $display("txn 3: out_data=%h out_max=%0d latency=%0d", out_data, out_max, at - t0);

    // 4: all results negative, start/select sequence.
    tbl_mode = 2;
    s0   = start_cnt;
    base = sel_log.size();
    accept(16'hFFFF, t0);
    wait_out_valid("t4_ov_wait", at);
    check("t4_latency", 64'(at - t0), 64'd25);
    check("t4_out_data", out_data, 64'hF800_F800_F800_F800);
    check("t4_out_max", 64'(out_max), 64'd0);
    release_out();
    check("t4_starts", 64'(start_cnt - s0), 64'd4);
    for (int k = 0; k < NUM_NEU; k++) begin
      if (base + k < sel_log.size())
        check("t4_sel_seq", 64'(sel_log[base + k]), 64'(k));
      else
        check("t4_sel_missing", 64'(sel_log.size() - base), 64'(NUM_NEU));
    end
    $display("txn 4: out_data=%h out_max=%0d", out_data, out_max);

    // 5: reset during neuron 1 WAIT; late result must be ignored.
    tbl_mode = 0;
    accept(16'h3C3C, t0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_eng_start", 64'(eng_start), 64'd0);
    check("t5_eng_sel", 64'(eng_sel), 64'd0);
    check("t5_err_clr", 64'(err_timeout), 64'd0);
    check("t5_out_max", 64'(out_max), 64'd0);
    check("t5_out_data", out_data, 64'd0);
    repeat (2) @(negedge clk);
    check("t5_late_busy", 64'(busy), 64'd0);
    check("t5_late_data", out_data, 64'd0);
    check("t5_late_max", 64'(out_max), 64'd0);
    check("t5_late_ov", 64'(out_valid), 64'd0);
    $display("txn 5: reset mid-layer, out_data=%h busy=%0d", out_data, busy);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
